// File: rtl/cep_encoder_ser.sv
// CEP packet serializer: registers a request/response packet image on input
// handshake and streams it out one WORD_WIDTH flit per cycle.
`ifndef CEP_WORD_WIDTH
`define CEP_WORD_WIDTH            64
`define CEP_IS_REQUEST_WIDTH      1
`define CEP_LAST_SUBLINE_WIDTH    1
`define CEP_SUBLINE_ID_WIDTH      2
`define CEP_MESI_WIDTH            2
`define CEP_MSHRID_WIDTH          8
`define CEP_MSG_TYPE_WIDTH        8
`define CEP_LENGTH_WIDTH          8
`define CEP_DATA_SIZE_WIDTH       3
`define CEP_CACHE_TYPE_WIDTH      1
`define CEP_ADDR_WIDTH            48
`define CEP_SRC_CHIPID_WIDTH      14
`define CEP_MSG_TYPE              7:0
`define CEP_MSHRID                15:8
`define CEP_LENGTH                23:16
`define CEP_MESI                  25:24
`define CEP_SUBLINE_ID            27:26
`define CEP_LAST_SUBLINE          28
`define CEP_IS_REQUEST            29
`define CEP_DATA_SIZE             32:30
`define CEP_CACHE_TYPE            33
`define CEP_SRC_CHIPID            47:34
`define CEP_ADDR                  111:64
`endif

module cep_encoder_ser #(
  parameter int WORD_WIDTH    = `CEP_WORD_WIDTH,
  parameter int NUM_WORDS     = 8,
  parameter int REQ_HDR_WORDS = 3,
  parameter int RSP_HDR_WORDS = 1,
  parameter int TRIM_EN       = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_val,
  output logic                                          in_rdy,
  input  logic [`CEP_IS_REQUEST_WIDTH-1:0]              is_request,
  input  logic [`CEP_LAST_SUBLINE_WIDTH-1:0]            last_subline,
  input  logic [`CEP_SUBLINE_ID_WIDTH-1:0]              subline_id,
  input  logic [`CEP_MESI_WIDTH-1:0]                    mesi,
  input  logic [`CEP_MSHRID_WIDTH-1:0]                  mshrid,
  input  logic [`CEP_MSG_TYPE_WIDTH-1:0]                msg_type,
  input  logic [`CEP_LENGTH_WIDTH-1:0]                  length,
  input  logic [`CEP_DATA_SIZE_WIDTH-1:0]               data_size,
  input  logic [`CEP_CACHE_TYPE_WIDTH-1:0]              cache_type,
  input  logic [`CEP_ADDR_WIDTH-1:0]                    addr,
  input  logic [`CEP_SRC_CHIPID_WIDTH-1:0]              src_chipid,
  input  logic [(NUM_WORDS-RSP_HDR_WORDS)*WORD_WIDTH-1:0] data,
  output logic                                          out_val,
  input  logic                                          out_rdy,
  output logic [WORD_WIDTH-1:0]                         out_data,
  output logic                                          out_last,
  output logic                                          busy
);

  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int DN = NUM_WORDS - RSP_HDR_WORDS;
  localparam int HW = REQ_HDR_WORDS * WORD_WIDTH;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                  state;
  logic [CW-1:0]                           idx;
  logic [CW-1:0]                           idx_nx;
  logic [CW-1:0]                           n_q;
  logic [CW-1:0]                           n_d;
  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]    pkt_q;
  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]    pkt_d;
  logic [DN-1:0][WORD_WIDTH-1:0]           data_w;
  logic [HW-1:0]                           hdr_flat;
  logic [REQ_HDR_WORDS-1:0][WORD_WIDTH-1:0] hdr_w;
  int                                      hdr_words;
  int                                      len_sat;
  logic                                    in_hs;

  assign data_w = data;
  assign hdr_w  = hdr_flat;
  assign idx_nx = idx + CW'(1);
  assign in_rdy = rst_n && ((state == IDLE) || (out_last && out_rdy));
  assign in_hs  = in_val && in_rdy;

  always_comb begin
    hdr_flat                   = '0;
    hdr_flat[`CEP_MSG_TYPE]    = msg_type;
    hdr_flat[`CEP_MSHRID]      = mshrid;
    hdr_flat[`CEP_LENGTH]      = length;
    hdr_flat[`CEP_MESI]        = mesi;
    hdr_flat[`CEP_SUBLINE_ID]  = subline_id;
    hdr_flat[`CEP_LAST_SUBLINE] = last_subline;
    hdr_flat[`CEP_IS_REQUEST]  = is_request;
    hdr_flat[`CEP_DATA_SIZE]   = data_size;
    hdr_flat[`CEP_CACHE_TYPE]  = cache_type;
    hdr_flat[`CEP_SRC_CHIPID]  = src_chipid;
    hdr_flat[`CEP_ADDR]        = addr;
  end

  // Packet image: header words, then only the `length` valid data words
  // (saturated to capacity); every other word stays zero.
  always_comb begin
    hdr_words = (is_request != '0) ? REQ_HDR_WORDS : RSP_HDR_WORDS;
    len_sat   = (int'(length) > NUM_WORDS - hdr_words) ? NUM_WORDS - hdr_words : int'(length);
    n_d       = (TRIM_EN != 0) ? CW'(hdr_words + len_sat) : CW'(NUM_WORDS);
    pkt_d     = '0;
    for (int i = 0; i < REQ_HDR_WORDS; i++) begin
      if (i < hdr_words) pkt_d[i] = hdr_w[i];
    end
    for (int i = 0; i < NUM_WORDS; i++) begin
      for (int j = 0; j < DN; j++) begin
        if (j < len_sat && j + hdr_words == i) pkt_d[i] = data_w[j];
      end
    end
  end

  // A new packet may load in the same edge the previous final flit leaves,
  // so the load branch takes priority over the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      n_q      <= '0;
      pkt_q    <= '0;
      out_val  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      busy     <= 1'b0;
    end else if (in_hs) begin
      state    <= SEND;
      idx      <= '0;
      n_q      <= n_d;
      pkt_q    <= pkt_d;
      out_val  <= 1'b1;
      out_last <= (n_d == CW'(1));
      out_data <= pkt_d[0];
      busy     <= 1'b1;
    end else if (state == SEND && out_rdy) begin
      if (out_last) begin
        state    <= IDLE;
        idx      <= '0;
        out_val  <= 1'b0;
        out_last <= 1'b0;
        out_data <= '0;
        busy     <= 1'b0;
      end else begin
        idx      <= idx_nx;
        out_last <= (idx_nx == n_q - CW'(1));
        out_data <= pkt_q[idx_nx[IW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_cep_encoder_ser.sv
// Bench for cep_encoder_ser: directed and random packets scored against a
// word-list model of the packet format.
`ifndef CEP_WORD_WIDTH
`define CEP_WORD_WIDTH            64
`define CEP_IS_REQUEST_WIDTH      1
`define CEP_LAST_SUBLINE_WIDTH    1
`define CEP_SUBLINE_ID_WIDTH      2
`define CEP_MESI_WIDTH            2
`define CEP_MSHRID_WIDTH          8
`define CEP_MSG_TYPE_WIDTH        8
`define CEP_LENGTH_WIDTH          8
`define CEP_DATA_SIZE_WIDTH       3
`define CEP_CACHE_TYPE_WIDTH      1
`define CEP_ADDR_WIDTH            48
`define CEP_SRC_CHIPID_WIDTH      14
`define CEP_MSG_TYPE              7:0
`define CEP_MSHRID                15:8
`define CEP_LENGTH                23:16
`define CEP_MESI                  25:24
`define CEP_SUBLINE_ID            27:26
`define CEP_LAST_SUBLINE          28
`define CEP_IS_REQUEST            29
`define CEP_DATA_SIZE             32:30
`define CEP_CACHE_TYPE            33
`define CEP_SRC_CHIPID            47:34
`define CEP_ADDR                  111:64
`endif

module tb_cep_encoder_ser;

  typedef struct {
    logic         req;
    logic         last_subline;
    logic [1:0]   subline_id;
    logic [1:0]   mesi;
    logic [7:0]   mshrid;
    logic [7:0]   msg_type;
    logic [7:0]   len;
    logic [2:0]   data_size;
    logic         cache_type;
    logic [47:0]  addr;
    logic [13:0]  chipid;
    logic [447:0] data;
  } pkt_t;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } flit_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_val, in_val0;
  logic         in_rdy, in_rdy0;
  logic         is_request, last_subline, cache_type;
  logic [1:0]   subline_id, mesi;
  logic [7:0]   mshrid, msg_type, length;
  logic [2:0]   data_size;
  logic [47:0]  addr;
  logic [13:0]  src_chipid;
  logic [447:0] data;
  logic         out_val, out_rdy, out_last, busy;
  logic [63:0]  out_data;
  logic         out_val0, out_rdy0, out_last0, busy0;
  logic [63:0]  out_data0;

  int    n_vec = 0;
  int    n_err = 0;
  pkt_t  pend[$];
  flit_t exp_q[$];

  always #5 clk = ~clk;

  cep_encoder_ser #(.TRIM_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy),
    .is_request(is_request), .last_subline(last_subline), .subline_id(subline_id),
    .mesi(mesi), .mshrid(mshrid), .msg_type(msg_type), .length(length),
    .data_size(data_size), .cache_type(cache_type), .addr(addr),
    .src_chipid(src_chipid), .data(data), .out_val(out_val), .out_rdy(out_rdy),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  cep_encoder_ser #(.TRIM_EN(0)) u_dut_notrim (
    .clk(clk), .rst_n(rst_n), .in_val(in_val0), .in_rdy(in_rdy0),
    .is_request(is_request), .last_subline(last_subline), .subline_id(subline_id),
    .mesi(mesi), .mshrid(mshrid), .msg_type(msg_type), .length(length),
    .data_size(data_size), .cache_type(cache_type), .addr(addr),
    .src_chipid(src_chipid), .data(data), .out_val(out_val0), .out_rdy(out_rdy0),
    .out_data(out_data0), .out_last(out_last0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic pkt_t make_pkt(input logic req, input logic [7:0] len);
    pkt_t p;
    p.req          = req;
    p.len          = len;
    p.last_subline = 1'($urandom);
    p.subline_id   = 2'($urandom);
    p.mesi         = 2'($urandom);
    p.mshrid       = 8'($urandom);
    p.msg_type     = 8'($urandom);
    p.data_size    = 3'($urandom);
    p.cache_type   = 1'($urandom);
    p.addr         = {16'($urandom), 32'($urandom)};
    p.chipid       = 14'($urandom);
    for (int k = 0; k < 14; k++) p.data[k*32 +: 32] = $urandom;
    return p;
  endfunction

  // Packet as a list of words: header words, min(len, room) data words, zeros.
  function automatic int build(input pkt_t p, input bit trim, output logic [63:0] w[8]);
    logic [191:0] h;
    int hn, nd;
    h = '0;
    h[`CEP_MSG_TYPE]     = p.msg_type;
    h[`CEP_MSHRID]       = p.mshrid;
    h[`CEP_LENGTH]       = p.len;
    h[`CEP_MESI]         = p.mesi;
    h[`CEP_SUBLINE_ID]   = p.subline_id;
    h[`CEP_LAST_SUBLINE] = p.last_subline;
    h[`CEP_IS_REQUEST]   = p.req;
    h[`CEP_DATA_SIZE]    = p.data_size;
    h[`CEP_CACHE_TYPE]   = p.cache_type;
    h[`CEP_SRC_CHIPID]   = p.chipid;
    h[`CEP_ADDR]         = p.addr;
    hn = p.req ? 3 : 1;
    nd = (int'(p.len) > 8 - hn) ? 8 - hn : int'(p.len);
    for (int k = 0; k < 8; k++) begin
      if (k < hn)           w[k] = h[k*64 +: 64];
      else if (k - hn < nd) w[k] = p.data[(k-hn)*64 +: 64];
      else                  w[k] = 64'd0;
    end
    return trim ? hn + nd : 8;
  endfunction

  task automatic push_model(input pkt_t p);
    logic [63:0] w[8];
    int n;
    flit_t f;
    n = build(p, 1'b1, w);
    for (int k = 0; k < n; k++) begin
      f.d = w[k];
      f.l = (k == n - 1);
      exp_q.push_back(f);
    end
  endtask

  task automatic apply(input pkt_t p);
    is_request   = p.req;
    last_subline = p.last_subline;
    subline_id   = p.subline_id;
    mesi         = p.mesi;
    mshrid       = p.mshrid;
    msg_type     = p.msg_type;
    length       = p.len;
    data_size    = p.data_size;
    cache_type   = p.cache_type;
    addr         = p.addr;
    src_chipid   = p.chipid;
    data         = p.data;
  endtask

  // Entered and left 1 time unit after a rising edge. mode 0: out_rdy=1,
  // mode 1: 1,0,0 repeating, mode 2: random. Stops early after abort_after flits.
  task automatic run_stream(input int mode, input int abort_after, output int flits);
    int cyc = 0;
    bit stalled = 0;
    logic [63:0] prev_d = '0;
    logic prev_l = 1'b0;
    bit will_out, will_in;
    flits = 0;
    while ((pend.size() > 0 || exp_q.size() > 0) && cyc < 400 &&
           !(abort_after >= 0 && flits >= abort_after)) begin
      check("out_val", out_val, exp_q.size() != 0);
      check("busy", busy, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("out_data", out_data, exp_q[0].d);
        check("out_last", out_last, exp_q[0].l);
      end
      if (stalled) begin
        check("stall_data", out_data, prev_d);
        check("stall_last", out_last, prev_l);
      end
      case (mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = (cyc % 3 == 0);
        default: out_rdy = 1'($urandom);
      endcase
      if (pend.size() > 0) begin
        apply(pend[0]);
        in_val = 1'b1;
      end else begin
        in_val = 1'b0;
      end
      #1;
      check("in_rdy", in_rdy, (exp_q.size() == 0) || (exp_q.size() == 1 && out_rdy));
      will_out = out_val && out_rdy;
      will_in  = in_val && in_rdy;
      stalled  = out_val && !out_rdy;
      prev_d   = out_data;
      prev_l   = out_last;
      @(posedge clk);
      if (will_out && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        flits++;
      end
      if (will_in) push_model(pend.pop_front());
      #1;
      cyc++;
    end
    in_val = 1'b0;
    check("stream_bounded", cyc < 400, 1'b1);
  endtask

  initial begin
    int nf;
    pkt_t p;
    logic [63:0] w[8];
    int n;
    rst_n = 1'b0; in_val = 1'b0; in_val0 = 1'b0; out_rdy = 1'b1; out_rdy0 = 1'b1;
    apply(make_pkt(1'b0, 8'd0));
    #3;
    check("rst_in_rdy", in_rdy, 1'b0);
    check("rst_out_val", out_val, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_last", out_last, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_rdy", in_rdy, 1'b1);

    // Response, length 7: 8 flits
    pend.push_back(make_pkt(1'b0, 8'd7));
    run_stream(0, -1, nf);
    check("rsp7_flits", nf, 8);

    // Request, length 2, fixed address: 5 flits
    p = make_pkt(1'b1, 8'd2);
    p.addr = 48'h0000_1234_5680;
    pend.push_back(p);
    run_stream(0, -1, nf);
    check("req2_flits", nf, 5);

    // Back-to-back 1-flit response then 3-flit request, no bubble
    pend.push_back(make_pkt(1'b0, 8'd0));
    pend.push_back(make_pkt(1'b1, 8'd0));
    run_stream(0, -1, nf);
    check("b2b_flits", nf, 4);

    // Backpressure 1,0,0 on an 8-flit packet
    pend.push_back(make_pkt(1'b0, 8'd7));
    run_stream(1, -1, nf);
    check("bp_flits", nf, 8);

    // Length saturation
    pend.push_back(make_pkt(1'b0, 8'd200));
    pend.push_back(make_pkt(1'b1, 8'd9));
    run_stream(0, -1, nf);
    check("sat_flits", nf, 16);

    // Random packets with random backpressure
    for (int k = 0; k < 12; k++) pend.push_back(make_pkt(1'($urandom), 8'($urandom_range(0, 10))));
    run_stream(2, -1, nf);

    // Reset mid-packet after three flits
    pend.push_back(make_pkt(1'b0, 8'd7));
    run_stream(0, 3, nf);
    rst_n = 1'b0;
    #1;
    check("midrst_out_val", out_val, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_rdy", in_rdy, 1'b0);
    check("midrst_out_data", out_data, 64'd0);
    exp_q.delete();
    pend.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_out_val", out_val, 1'b0);
    pend.push_back(make_pkt(1'b0, 8'd1));
    run_stream(0, -1, nf);
    check("postrst_flits", nf, 2);

    // Untrimmed instance: request length 1 gives 8 flits, zero tail
    p = make_pkt(1'b1, 8'd1);
    n = build(p, 1'b0, w);
    apply(p);
    in_val0 = 1'b1;
    #1;
    check("notrim_in_rdy", in_rdy0, 1'b1);
    @(posedge clk); #1;
    in_val0 = 1'b0;
    for (int k = 0; k < n; k++) begin
      check("notrim_val", out_val0, 1'b1);
      check("notrim_data", out_data0, w[k]);
      check("notrim_last", out_last0, k == n - 1);
      @(posedge clk); #1;
    end
    check("notrim_count", n, 8);
    check("notrim_done", out_val0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cep_encoder_ser.md
CEP_ENCODER_SER -- requirements
Module: cep_encoder_ser

Interface
REQ-001 Parameter WORD_WIDTH, default `CEP_WORD_WIDTH (64): flit and CEP word width in bits.
REQ-002 Parameter NUM_WORDS, default 8: words per full CEP packet; packet width is NUM_WORDS*WORD_WIDTH.
REQ-003 Parameter REQ_HDR_WORDS, default 3: header words in a request packet.
REQ-004 Parameter RSP_HDR_WORDS, default 1: header words in a response packet.
REQ-005 Parameter TRIM_EN, default 1: 1 means send only the header plus `length` data words; 0 means always send NUM_WORDS flits.
REQ-006 Ports: clk, input, 1, clock; all logic is rising-edge.
REQ-007 Ports: rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-008 Ports: in_val input 1 and in_rdy output 1: input packet handshake.
REQ-009 Ports: is_request, last_subline, subline_id, mesi, mshrid, msg_type, length, data_size, cache_type, addr, src_chipid: inputs at their `CEP_*_WIDTH widths, sampled only on input handshake.
REQ-010 Ports: data, input, (NUM_WORDS-RSP_HDR_WORDS)*WORD_WIDTH, payload; word i occupies bits [(i+1)*WORD_WIDTH-1 : i*WORD_WIDTH].
REQ-011 Ports: out_val output 1, out_rdy input 1, out_data output WORD_WIDTH, out_last output 1 (flags the final flit of a packet).
REQ-012 Ports: busy, output, 1: high whenever a packet is held.

Function
REQ-013 Input handshake occurs when in_val && in_rdy are both high at a rising edge of clk.
REQ-014 On input handshake, the block SHALL build the packet image and register it.
- Header fields go to their `CEP_* bit positions (cep_defines.vh); unused header bits are 0.
- Request: REQ_HDR_WORDS header words, then data words 0..NUM_WORDS-REQ_HDR_WORDS-1.
- Response: RSP_HDR_WORDS header words, then data words 0..NUM_WORDS-RSP_HDR_WORDS-1.
- Excess input data words are discarded; unused packet words are 0.
REQ-015 Flit count N per packet:
- TRIM_EN=1: N = hdr + min(length, NUM_WORDS-hdr), where hdr is the header word count for the packet type.
- TRIM_EN=0: N = NUM_WORDS.
- Counter width is clog2(NUM_WORDS+1).
REQ-016 The FSM has two states, IDLE and SEND.
- IDLE: out_val=0, in_rdy=1; an input handshake moves to SEND with word index 0.
REQ-017 SEND state:
- out_val=1 and out_data = packet word[idx].
- out_last = 1 when idx == N-1.
- On out_val && out_rdy, idx increments.
REQ-018 Latency: packet accepted at edge k; word 0 SHALL appear on out_data in the cycle after edge k. Output is registered, with no combinational path from inputs to out_data.
REQ-019 While out_val && !out_rdy, out_data, out_last and idx SHALL hold stable.
REQ-020 in_rdy is high in IDLE, or in SEND when out_last && out_rdy (final flit consumed that cycle). It is low otherwise.
REQ-021 Final flit consumed with a simultaneous input handshake: load the new packet, stay in SEND, idx=0. There SHALL be no bubble cycle.
REQ-022 Final flit consumed with no input handshake: go to IDLE.
REQ-023 length=0 with TRIM_EN=1: header only (N=hdr).
REQ-024 length at or above capacity saturates to NUM_WORDS-hdr.
REQ-025 busy = (state==SEND).

Reset
REQ-026 While rst_n=0, regardless of clk, the block SHALL force:
- state=IDLE, idx=0, packet register=0;
- out_val=0, out_last=0, out_data=0, in_rdy=1 is permitted only after release (in_rdy=0 during reset), busy=0.
REQ-027 Reset asserted mid-packet SHALL discard the packet. No partial flits follow after release; the first flit after release belongs to a newly accepted packet.

Verification
REQ-028 Response packet, length=7, TRIM_EN=1, out_rdy=1: 8 flits on consecutive cycles.
- Flit 0 is the header with the is_request bit = 0.
- Flits 1..7 = data words 0..6.
- out_last only on flit 7.
- in_rdy high in the flit-7 cycle.
REQ-029 Request packet, length=2, addr=0x0000_1234_5680: 5 flits.
- Flits 0..2 are the header; addr sits at the `CEP_ADDR bits.
- Flits 3,4 = data words 0,1.
- out_last on flit 4.
REQ-030 Back-to-back packets: response length=0 (1 flit) then request length=0 (3 flits), in_val held high, out_rdy=1.
- Exactly 4 consecutive flits with no idle cycle.
- out_last on flit 0 and flit 3.
REQ-031 Backpressure: out_rdy toggled 1,0,0,1,... during an 8-flit packet.
- out_data/out_last stable across stalled cycles.
- All 8 words delivered once, in order.
- in_rdy=0 until the final flit is consumed.
REQ-032 rst_n pulsed low after flit 2 of 8:
- out_val=0 and busy=0 immediately.
- After release, a new length=1 response yields exactly 2 flits.
REQ-033 TRIM_EN=0, length=1 request: 8 flits; flits 4..7 are zero.
